fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the pipelined core: holds the program counter, drives the word address into the combinational instruction memory, and captures the returned instruction into the IF/ID pipeline register. It sits directly upstream of the instruction memory, feeding its address input, and directly upstream of decode, to which it presents INSTRD/PCPLUS4D/VALIDD. It accepts stall, flush and branch/jump redirects from the hazard unit and execute/decode stages.

## Interface
- AWL, 6, instruction-memory word-address width (memory holds 2**AWL words)
- DWL, 32, instruction width
- RESET_PC, 32'h0000_0000, PC value loaded on reset (low two bits must be 0)
- CLK  in  1  rising-edge clock
- RSTN  in  1  asynchronous, active-low reset
- STALLF  in  1  1 = hold PCF
- STALLD  in  1  1 = hold IF/ID register
- FLUSHD  in  1  1 = load bubble into IF/ID register
- PCSRC  in  2  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 jump
- PCBRANCH  in  32  branch target byte address
- PCJUMP  in  32  jump target byte address
- IMRD  in  DWL  instruction word returned by instruction memory (same cycle)
- IMA  out  AWL  instruction-memory word address = PCF[AWL+1:2]
- PCF  out  32  current fetch PC (registered)
- PCPLUS4F  out  32  PCF + 4 (combinational)
- INSTRD  out  DWL  IF/ID instruction
- PCPLUS4D  out  32  IF/ID PC+4
- VALIDD  out  1  IF/ID holds a real fetched instruction

## Operation
- PC register: on RSTN low, PCF = RESET_PC immediately. Each rising edge with RSTN high and STALLF = 0: PCF <= PCNEXT; STALLF = 1: PCF holds.
- PCNEXT: PCSRC 00 -> PCF+4; 01 -> {PCBRANCH[31:2],2'b00}; 10/11 -> {PCJUMP[31:2],2'b00}. Target low two bits are always forced to 0.
- PCF+4 is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- IMA is a pure slice of PCF; byte addresses at or above 4*2**AWL alias into the memory (no error). IMA never depends on IMRD or redirect inputs combinationally.
- IF/ID register, priority FLUSHD > STALLD > load:
  - FLUSHD = 1: INSTRD <= 0 (NOP), PCPLUS4D <= 0, VALIDD <= 0.
  - else STALLD = 1: all three hold.
  - else: INSTRD <= IMRD, PCPLUS4D <= PCPLUS4F, VALIDD <= 1.
- Reset values: PCF = RESET_PC, INSTRD = 0, PCPLUS4D = 0, VALIDD = 0; IMA = RESET_PC[AWL+1:2].
- STALLF and STALLD are independent; the hazard unit normally asserts both together. STALLF = 1 with a redirect on PCSRC: redirect is dropped (PC holds); the requester must keep PCSRC asserted until a non-stalled cycle.
- FLUSHD with STALLF = 0 and a redirect in the same cycle: PC loads the target and IF/ID gets a bubble (taken-branch squash).

## Timing
- Single clock domain, all state on rising CLK; reset asynchronous assert, released synchronously by the environment.
- Fetch latency: instruction at address A appears on INSTRD one edge after PCF = A (memory is combinational).
- Redirect penalty: target instruction reaches INSTRD two edges after the redirect edge's preceding cycle; the wrong-path instruction is removed by FLUSHD.
- Reset asserted mid-run: PCF, INSTRD, PCPLUS4D, VALIDD return to reset values without waiting for CLK; first post-reset edge captures ROM[RESET_PC>>2] with VALIDD = 1.
- No combinational path from STALL/FLUSH/PCSRC to any output except PCPLUS4F (none) and IMA (none).

## Test plan
- Reset then run: RESET_PC = 0, ROM[0..3] = distinct words, no stalls -> PCF = 0,4,8,12 on successive edges; INSTRD = ROM[0],ROM[1],ROM[2] one edge later; PCPLUS4D = 4,8,12; VALIDD = 0 then 1.
- Stall: assert STALLF and STALLD for 2 cycles at PCF = 8 -> PCF stays 8, INSTRD stays ROM[1] for 2 edges, then resumes with ROM[2].
- Branch + flush: PCF = 12, PCSRC = 01, PCBRANCH = 32'h0000_0023, FLUSHD = 1 -> next PCF = 32'h20, VALIDD = 0, INSTRD = 0; following edge INSTRD = ROM[8], PCPLUS4D = 32'h24.
- Jump and priority: PCSRC = 11, PCJUMP = 32'h40, FLUSHD = 1 and STALLD = 1 simultaneously -> PCF = 32'h40, IF/ID flushed (flush beats stall); with AWL = 6, IMA = 16.
- Wrap/alias: PCF = 32'hFFFF_FFFC, PCSRC = 00 -> PCF = 0, PCPLUS4D = 0; PCF = 32'h100 -> IMA = 0 (alias).
- Async reset mid-run: drop RSTN between edges at PCF = 32'h20 -> PCF = RESET_PC, VALIDD = 0 before next edge; restart fetches ROM[0].

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, instruction-memory word address,
// and the IF/ID pipeline register feeding decode.
module fetch_stage #(
  parameter int unsigned AWL      = 6,
  parameter int unsigned DWL      = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           STALLF,
  input  logic           STALLD,
  input  logic           FLUSHD,
  input  logic [1:0]     PCSRC,
  input  logic [31:0]    PCBRANCH,
  input  logic [31:0]    PCJUMP,
  input  logic [DWL-1:0] IMRD,
  output logic [AWL-1:0] IMA,
  output logic [31:0]    PCF,
  output logic [31:0]    PCPLUS4F,
  output logic [DWL-1:0] INSTRD,
  output logic [31:0]    PCPLUS4D,
  output logic           VALIDD
);

  logic [31:0] pcnext;

  assign PCPLUS4F = PCF + 32'd4;
  assign IMA      = PCF[AWL+1:2];

  // Redirect targets are word-aligned by masking, so misaligned requests never reach PCF.
  always_comb begin
    pcnext = PCPLUS4F;
    unique case (PCSRC)
      2'b00:   pcnext = PCPLUS4F;
      2'b01:   pcnext = PCBRANCH & ~32'd3;
      default: pcnext = PCJUMP & ~32'd3;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      PCF <= RESET_PC;
    end else if (!STALLF) begin
      PCF <= pcnext;
    end
  end

  // Flush outranks stall so a squashed slot never survives a held pipeline.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      INSTRD   <= '0;
      PCPLUS4D <= '0;
      VALIDD   <= 1'b0;
    end else if (FLUSHD) begin
      INSTRD   <= '0;
      PCPLUS4D <= '0;
      VALIDD   <= 1'b0;
    end else if (!STALLD) begin
      INSTRD   <= IMRD;
      PCPLUS4D <= PCPLUS4F;
      VALIDD   <= 1'b1;
    end
  end

endmodule
